// File: rtl/me_wb_mem_if.sv
// me_wb_mem_if: data-memory req/ack bus between the memory-stage controller and data memory.
interface me_wb_mem_if;
  localparam int unsigned DW = 32;

  logic          dm_req;
  logic          dm_we;
  logic [DW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;

  modport master (output dm_req, dm_we, dm_addr, dm_wdata, input dm_rdata, dm_ack);
  modport slave  (input dm_req, dm_we, dm_addr, dm_wdata, output dm_rdata, dm_ack);
endinterface

// File: rtl/me_wb_mem.sv
// me_wb_mem: memory-stage req/ack controller and MEM/WB pipeline register.
// Optional feature: define MEM_TIMEOUT_EN to build the WAIT timeout counter and sticky mem_err.
module me_wb_mem #(
  parameter  int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned DW = 32,
  localparam int unsigned RW = 5,
  localparam int unsigned SW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] pc8_M,
  input  logic [DW-1:0] ALUOut_M,
  input  logic [DW-1:0] WriteData_M,
  input  logic [RW-1:0] WriteReg_M,
  input  logic          RegWrite_M,
  input  logic          MemWrite_M,
  input  logic          Jal_M,
  input  logic [SW-1:0] MemtoReg_M,
  me_wb_mem_if.master   dm,
  output logic          stall_M,
  output logic [DW-1:0] pc8_W,
  output logic [DW-1:0] ALUOut_W,
  output logic [DW-1:0] ReadData_W,
  output logic [RW-1:0] WriteReg_W,
  output logic          RegWrite_W,
  output logic          Jal_W,
  output logic [SW-1:0] MemtoReg_W,
  output logic          mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          we_q, we_d;

  logic [DW-1:0] pc8_q, pc8_d;
  logic [DW-1:0] alu_q, alu_d;
  logic [DW-1:0] rd_q, rd_d;
  logic [RW-1:0] wr_q, wr_d;
  logic          rw_q, rw_d;
  logic          jal_q, jal_d;
  logic [SW-1:0] mtr_q, mtr_d;

  logic          need_access;
  logic          stall_raw;
  logic          load_m;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  logic          unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  assign need_access = MemWrite_M | (MemtoReg_M == 2'b01);

  // Next-state, bus latches and W-register next value
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    stall_raw = 1'b0;
    load_m    = 1'b0;
    rd_d      = '0;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (need_access) begin
          stall_raw = 1'b1;
          addr_d    = {ALUOut_M[DW-1:2], 2'b00};
          wdata_d   = WriteData_M;
          we_d      = MemWrite_M;
          state_d   = S_WAIT;
`ifdef MEM_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end else begin
          load_m = 1'b1;
        end
      end
      S_WAIT: begin
        stall_raw = 1'b1;
        if (dm.dm_ack) begin
          rdata_d = dm.dm_rdata;
          state_d = S_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
            rdata_d = DW'(32'hDEADBEEF);
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
`endif
      end
      S_DONE: begin
        load_m  = 1'b1;
        rd_d    = rdata_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bubble unless the M bundle retires into W this cycle
    pc8_d = '0;
    alu_d = '0;
    wr_d  = '0;
    rw_d  = 1'b0;
    jal_d = 1'b0;
    mtr_d = '0;
    if (load_m) begin
      pc8_d = pc8_M;
      alu_d = ALUOut_M;
      wr_d  = WriteReg_M;
      rw_d  = RegWrite_M;
      jal_d = Jal_M;
      mtr_d = MemtoReg_M;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      pc8_q   <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      rw_q    <= 1'b0;
      jal_q   <= 1'b0;
      mtr_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      pc8_q   <= pc8_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rw_q    <= rw_d;
      jal_q   <= jal_d;
      mtr_q   <= mtr_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Stall is suppressed while reset is held so the front end sees a clean pipeline
  assign stall_M     = reset & stall_raw;

  assign dm.dm_req   = (state_q == S_WAIT);
  assign dm.dm_we    = (state_q == S_WAIT) & we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;

  assign pc8_W       = pc8_q;
  assign ALUOut_W    = alu_q;
  assign ReadData_W  = rd_q;
  assign WriteReg_W  = wr_q;
  assign RegWrite_W  = rw_q;
  assign Jal_W       = jal_q;
  assign MemtoReg_W  = mtr_q;

`ifdef MEM_TIMEOUT_EN
  assign mem_err     = err_q;
`else
  assign mem_err     = 1'b0;
`endif

endmodule

// File: tb/tb_me_wb_mem.sv
// tb_me_wb_mem: randomized scoreboard bench for me_wb_mem against an instruction-level model.
module tb_me_wb_mem;
  localparam int unsigned TMO = 4;

  typedef struct packed {
    logic [31:0] pc8, alu, wd;
    logic [4:0]  wr;
    logic        rw, mw, jal;
    logic [1:0]  mtr;
  } instr_t;

  typedef struct packed {
    logic [31:0] pc8, alu, rd;
    logic [4:0]  wr;
    logic        rw, jal;
    logic [1:0]  mtr;
    logic        err;
  } wexp_t;

  typedef struct packed {
    logic        stall, req, we;
    logic [31:0] addr, wdata;
  } cexp_t;

  logic        clk;
  logic        reset;
  logic [31:0] pc8_M, ALUOut_M, WriteData_M;
  logic [4:0]  WriteReg_M;
  logic        RegWrite_M, MemWrite_M, Jal_M;
  logic [1:0]  MemtoReg_M;
  logic        stall_M;
  logic [31:0] pc8_W, ALUOut_W, ReadData_W;
  logic [4:0]  WriteReg_W;
  logic        RegWrite_W, Jal_W;
  logic [1:0]  MemtoReg_W;
  logic        mem_err;

  me_wb_mem_if dm_bus ();

  me_wb_mem #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .pc8_M(pc8_M), .ALUOut_M(ALUOut_M), .WriteData_M(WriteData_M),
    .WriteReg_M(WriteReg_M), .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M),
    .Jal_M(Jal_M), .MemtoReg_M(MemtoReg_M),
    .dm(dm_bus),
    .stall_M(stall_M),
    .pc8_W(pc8_W), .ALUOut_W(ALUOut_W), .ReadData_W(ReadData_W),
    .WriteReg_W(WriteReg_W), .RegWrite_W(RegWrite_W), .Jal_W(Jal_W),
    .MemtoReg_W(MemtoReg_W), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cexp_t ctl_q[$];
  wexp_t w_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    mon_en = 1'b0;
  bit    err_m = 1'b0;

  function automatic wexp_t w_of(input instr_t in, input logic [31:0] rd, input bit err);
    wexp_t w;
    w = '{in.pc8, in.alu, rd, in.wr, in.rw, in.jal, in.mtr, err};
    return w;
  endfunction

  function automatic wexp_t bubble(input bit err);
    wexp_t w;
    w = '0;
    w.err = err;
    return w;
  endfunction

  function automatic instr_t rand_instr(input bit mem);
    instr_t r;
    r.pc8 = $urandom; r.alu = $urandom; r.wd = $urandom;
    r.wr  = 5'($urandom); r.rw = 1'($urandom); r.jal = 1'($urandom);
    if (mem) begin
      if ($urandom_range(0, 1) == 1) begin r.mw = 1'b1; r.mtr = 2'($urandom); end
      else begin r.mw = 1'b0; r.mtr = 2'b01; end
    end else begin
      r.mw = 1'b0;
      do r.mtr = 2'($urandom); while (r.mtr == 2'b01);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input instr_t in);
    pc8_M = in.pc8; ALUOut_M = in.alu; WriteData_M = in.wd; WriteReg_M = in.wr;
    RegWrite_M = in.rw; MemWrite_M = in.mw; Jal_M = in.jal; MemtoReg_M = in.mtr;
  endtask

  // One clock of stimulus; queues the expected bus view for this cycle and W after its closing edge
  task automatic cycle(input instr_t in, input logic rst, input logic ack, input logic [31:0] rdata,
                       input cexp_t c, input wexp_t w);
    @(posedge clk); #1;
    reset = rst;
    drive(in);
    dm_bus.dm_ack   = ack;
    dm_bus.dm_rdata = rdata;
    ctl_q.push_back(c);
    w_q.push_back(w);
    mon_en = 1'b1;
  endtask

  // Instruction-level model: ALU ops take 1 cycle, memory ops 1 + N + 1 cycles
  task automatic run_instr(input instr_t in, input int ack_at, input logic [31:0] ack_data);
    logic [31:0] addr, rd;
    int n;
    if (!(in.mw || in.mtr == 2'b01)) begin
      cycle(in, 1'b1, 1'($urandom), $urandom, '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0}, w_of(in, 32'h0, err_m));
    end else begin
      addr = in.alu & 32'hFFFF_FFFC;
      cycle(in, 1'b1, 1'($urandom), $urandom, '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0}, bubble(err_m));
      n  = (ack_at == 0) ? int'(TMO) : ack_at;
      rd = 32'hDEADBEEF;
      for (int j = 1; j <= n; j++) begin
        if (j == ack_at) begin
          rd = ack_data;
          cycle(in, 1'b1, 1'b1, ack_data, '{1'b1, 1'b1, in.mw, addr, in.wd}, bubble(err_m));
        end else begin
          if (j == n) err_m = 1'b1;
          cycle(in, 1'b1, 1'b0, $urandom, '{1'b1, 1'b1, in.mw, addr, in.wd}, bubble(err_m));
        end
      end
      cycle(in, 1'b1, 1'($urandom), $urandom, '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0}, w_of(in, rd, err_m));
    end
  endtask

  cexp_t mc;
  wexp_t mw, aw;

  // Monitor: bus view of the current cycle, W registers from the previous edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (ctl_q.size() == 0 || w_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL scoreboard_underflow: got ctl=%0d w=%0d entries expected >=1", ctl_q.size(), w_q.size());
      end else begin
        mc = ctl_q.pop_front();
        mw = w_q.pop_front();
        chk("stall_req_we", 128'({stall_M, dm_bus.dm_req, dm_bus.dm_we}), 128'({mc.stall, mc.req, mc.we}));
        if (mc.req)
          chk("addr_wdata", 128'({dm_bus.dm_addr, dm_bus.dm_wdata}), 128'({mc.addr, mc.wdata}));
        aw = '{pc8_W, ALUOut_W, ReadData_W, WriteReg_W, RegWrite_W, Jal_W, MemtoReg_W, mem_err};
        chk("w_stage", 128'(aw), 128'(mw));
      end
    end
  end

  initial begin
    instr_t in, ld, nop;
    logic [31:0] addr;

    reset = 1'b0;
    drive(rand_instr(1'b1));
    dm_bus.dm_ack   = 1'b1;
    dm_bus.dm_rdata = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 128'(stall_M), 128'(0));
    chk("rst_dm", 128'({dm_bus.dm_req, dm_bus.dm_we, dm_bus.dm_addr, dm_bus.dm_wdata}), 128'(0));
    chk("rst_w", 128'({pc8_W, ALUOut_W, ReadData_W, WriteReg_W, RegWrite_W, Jal_W, MemtoReg_W}), 128'(0));
    chk("rst_err", 128'(mem_err), 128'(0));
    w_q.push_back(bubble(1'b0));

    in = '0; in.alu = 32'h1234; in.rw = 1'b1; in.wr = 5'd5;
    run_instr(in, 1, 32'h0);
    in = '0; in.mtr = 2'b01; in.alu = 32'h103; in.rw = 1'b1; in.wr = 5'd9;
    run_instr(in, 3, 32'hCAFEF00D);
    in = '0; in.mw = 1'b1; in.wd = 32'hA5A5A5A5; in.alu = 32'h2002;
    run_instr(in, 1, $urandom);
    run_instr(rand_instr(1'b1), 2, $urandom);
    run_instr(rand_instr(1'b1), 1, $urandom);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) run_instr(rand_instr(1'b1), $urandom_range(1, int'(TMO)), $urandom);
      else run_instr(rand_instr(1'b0), 1, 32'h0);
    end

    // Reset during the second WAIT cycle, then a late ack that must be ignored
    ld = rand_instr(1'b1); ld.mw = 1'b0; ld.mtr = 2'b01;
    addr = ld.alu & 32'hFFFF_FFFC;
    cycle(ld, 1'b1, 1'b0, $urandom, '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0}, bubble(err_m));
    cycle(ld, 1'b1, 1'b0, $urandom, '{1'b1, 1'b1, 1'b0, addr, ld.wd}, bubble(err_m));
    err_m = 1'b0;
    cycle(ld, 1'b0, 1'b0, $urandom, '{1'b0, 1'b1, 1'b0, addr, ld.wd}, bubble(1'b0));
    for (int i = 0; i < 3; i++) begin
      nop = rand_instr(1'b0);
      cycle(nop, 1'b1, 1'b1, $urandom, '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0}, w_of(nop, 32'h0, 1'b0));
    end
    run_instr(rand_instr(1'b1), 1, $urandom);

`ifdef MEM_TIMEOUT_EN
    in = rand_instr(1'b1); in.mw = 1'b0; in.mtr = 2'b01;
    run_instr(in, 0, 32'h0);
    in = '0; in.alu = 32'h55; in.rw = 1'b1; in.wr = 5'd3;
    run_instr(in, 1, 32'h0);
    run_instr(rand_instr(1'b1), int'(TMO), $urandom);
`endif

    run_instr(rand_instr(1'b0), 1, 32'h0);
    @(posedge clk); #1;
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/me_wb_mem.md
# me_wb_mem

Memory-stage controller and MEM/WB pipeline register for the 5-stage MIPS core. It consumes the M-stage bundle produced by the EX/MEM register and drives data-memory accesses over a req/ack handshake. It stalls the front of the pipeline while an access is outstanding and registers results into the W stage.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum WAIT cycles before a forced completion. Used only with `MEM_TIMEOUT_EN`.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: reset. One clock; reset is synchronous and active-low (`reset`==0 resets on the rising edge of `clk`).
- `pc8_M` in 32: PC+8 of the M-stage instruction.
- `ALUOut_M` in 32: ALU result and memory byte address.
- `WriteData_M` in 32: store data.
- `WriteReg_M` in 5: destination register.
- `RegWrite_M`, `MemWrite_M`, `Jal_M` in 1 each: control.
- `MemtoReg_M` in 2: writeback select. 00 = ALU, 01 = memory, 10 = pc8, 11 = ALU.
- `dm_rdata` in 32: memory read data, valid with `dm_ack`.
- `dm_ack` in 1: access complete. Sampled only in WAIT.
- `dm_req`, `dm_we` out 1: request and write enable.
- `dm_addr` out 32: word address `{addr[31:2],2'b00}`.
- `dm_wdata` out 32: store data.
- `stall_M` out 1: freezes PC, IF/ID, ID/EX and EX/MEM.
- `pc8_W`, `ALUOut_W`, `ReadData_W` out 32: W-stage data.
- `WriteReg_W` out 5: W-stage destination register.
- `RegWrite_W`, `Jal_W` out 1: W-stage control.
- `MemtoReg_W` out 2: W-stage writeback select.
- `mem_err` out 1: sticky timeout flag.

## Operation
- `need_access` = `MemWrite_M` | (`MemtoReg_M`==2'b01).
- FSM states: IDLE, WAIT, DONE.
- IDLE, `need_access`=0: W register loads the M bundle; `ReadData_W` loads 0; no stall.
- IDLE, `need_access`=1:
  - `stall_M`=1; W register loads a bubble.
  - Latch address, `WriteData_M` and `MemWrite_M` into `addr_q`, `wdata_q`, `we_q`.
  - Next state WAIT.
- WAIT:
  - `dm_req`=1; `dm_addr`/`dm_wdata`/`dm_we` driven from the latched regs and held stable.
  - `stall_M`=1; W register loads a bubble.
  - On `dm_ack`=1: capture `dm_rdata` into `rdata_q`; next state DONE.
- DONE:
  - `stall_M`=0; `dm_req`=0.
  - W register loads the M bundle with `ReadData_W`=`rdata_q` (stores: `rdata_q` is don't-care; `RegWrite_M` is normally 0).
  - Next state IDLE.
- Bubble = `RegWrite_W`=0, `MemtoReg_W`=0, `Jal_W`=0, `WriteReg_W`=0, `ALUOut_W`=0, `pc8_W`=0, `ReadData_W`=0.
- Upstream holds the M bundle stable while `stall_M`=1. The block still uses the latched address and data for the bus.
- `stall_M` is combinational: (state==IDLE & `need_access`) | state==WAIT.
- `dm_req` and `dm_we` are decoded from registered state and `we_q` only.
- `dm_ack` outside WAIT is ignored.
- Low address bits [1:0] are dropped; no alignment exception.

## Timing
- Reset values: state IDLE; every W output 0; `dm_req`=0, `dm_we`=0; `dm_addr`=0, `dm_wdata`=0; `mem_err`=0; timeout counter 0.
- Non-memory instruction: 1 cycle in M, W outputs valid after the next edge.
- Memory instruction: occupies M for 2 + N cycles, where N ≥ 1 is the number of WAIT cycles up to and including the `dm_ack` cycle.
  - Minimum 3 cycles (ack in the first WAIT cycle).
  - W outputs are valid after the edge ending DONE.
- Back-to-back memory instructions: DONE→IDLE, then the next access starts. `dm_req` drops for at least 2 cycles between requests.
- Reset asserted in any state: next edge enters IDLE with all outputs at reset values. An in-flight request is abandoned (`dm_req` low after that edge).

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, go to DONE with `rdata_q`=32'hDEADBEEF.
  - `mem_err` is set and stays 1 until reset.
  - An ack in the same cycle as the timeout wins (normal capture, no error).
- Undefined: WAIT persists until `dm_ack`; no counter is built; `mem_err` is tied to 0.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with random inputs -> all outputs 0, `stall_M`=0.
- ALU instruction: `ALUOut_M`=0x1234, `RegWrite_M`=1, `WriteReg_M`=5 -> next edge `ALUOut_W`=0x1234, `RegWrite_W`=1, `WriteReg_W`=5, `stall_M` never high.
- Load, ack after 3 cycles:
  - Stimulus: `MemtoReg_M`=01, `ALUOut_M`=0x103, `dm_rdata`=0xCAFEF00D.
  - Response: `dm_addr`=0x100; `stall_M` high 4 cycles; bubbles on W during the stall; then `ReadData_W`=0xCAFEF00D, `MemtoReg_W`=01.
- Store, immediate ack: `MemWrite_M`=1, `WriteData_M`=0xA5A5A5A5 -> `dm_we`=1, `dm_wdata`=0xA5A5A5A5, `dm_req` high exactly 1 cycle, `stall_M` high 2 cycles.
- Reset mid-WAIT: drop `reset` during the 2nd WAIT cycle -> `dm_req`=0 after that edge; a late `dm_ack` afterwards has no effect.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, load with no ack -> `ReadData_W`=0xDEADBEEF; `mem_err`=1 and stays 1 through a following ALU instruction.
